// File: rtl/perf_event_counter_bank_pkg.sv
// Shared types and constants for the perf-monitor counter bank.
package perf_event_counter_bank_pkg;

  localparam int PERF_EVENT_NUM = 32;
  localparam int PERF_CNT_NUM   = 8;
  localparam int PERF_CNT_WIDTH = 64;
  localparam int PERF_INC_WIDTH = 3;

  localparam int CNT_IDX_W = $clog2(PERF_CNT_NUM);
  localparam int EVT_IDX_W = $clog2(PERF_EVENT_NUM);

  typedef enum logic [1:0] {IDLE, SNAP, SEND} dump_state_t;

  // One streamed dump beat: which counter, and its snapshot value.
  typedef struct packed {
    logic [CNT_IDX_W-1:0]      idx;
    logic [PERF_CNT_WIDTH-1:0] data;
  } perf_dump_beat_t;

endpackage

// File: rtl/perf_event_counter_bank_slot.sv
// One programmable counter: event select, increment pipe, counter, sticky overflow.
module perf_counter_slot #(
  parameter int EVENT_NUM = 32,
  parameter int CNT_WIDTH = 64,
  parameter int INC_WIDTH = 3,
  parameter int SEL_W     = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [EVENT_NUM*INC_WIDTH-1:0] event_inc,
  input  logic                           inhibit,
  input  logic                           sel_we,
  input  logic [SEL_W-1:0]               sel_wdata,
  input  logic                           cnt_we,
  input  logic [CNT_WIDTH-1:0]           cnt_wdata,
  output logic [CNT_WIDTH-1:0]           cnt,
  output logic [CNT_WIDTH-1:0]           cnt_nxt,
  output logic                           ovf
);

  logic [SEL_W-1:0]     r_sel;
  logic [INC_WIDTH-1:0] r_inc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;

  logic [INC_WIDTH-1:0] w_inc;
  logic [CNT_WIDTH:0]   w_sum;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_ovf_nxt;

  // Event select mux; a select value with no matching event yields 0.
  always_comb begin
    w_inc = '0;
    for (int e = 0; e < EVENT_NUM; e++)
      if (r_sel == SEL_W'(e)) w_inc = event_inc[e*INC_WIDTH +: INC_WIDTH];
  end

  // Next counter value: a write wins over the pending add and clears overflow.
  always_comb begin
    w_sum     = {1'b0, r_cnt} + (CNT_WIDTH+1)'(r_inc);
    w_cnt_nxt = w_sum[CNT_WIDTH-1:0];
    w_ovf_nxt = r_ovf | w_sum[CNT_WIDTH];
    if (cnt_we) begin
      w_cnt_nxt = cnt_wdata;
      w_ovf_nxt = 1'b0;
    end
  end

  // Select register and stage-0 increment register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel <= '0;
      r_inc <= '0;
    end else begin
      r_inc <= inhibit ? '0 : w_inc;
      if (sel_we) r_sel <= sel_wdata;
    end
  end

  // Stage-1 counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign cnt     = r_cnt;
  assign cnt_nxt = w_cnt_nxt;
  assign ovf     = r_ovf;

endmodule

// File: rtl/perf_event_counter_bank.sv
// Performance counter bank: CNT_NUM event counters, CSR read path, snapshot dump streamer.
module perf_event_counter_bank
  import perf_event_counter_bank_pkg::*;
#(
  parameter int EVENT_NUM = PERF_EVENT_NUM,
  parameter int CNT_NUM   = PERF_CNT_NUM,
  parameter int CNT_WIDTH = PERF_CNT_WIDTH,
  parameter int INC_WIDTH = PERF_INC_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [EVENT_NUM*INC_WIDTH-1:0] event_inc,
  input  logic [CNT_NUM-1:0]             inhibit,
  input  logic                           cfg_we,
  input  logic [$clog2(CNT_NUM)-1:0]     cfg_idx,
  input  logic [$clog2(EVENT_NUM)-1:0]   cfg_sel,
  input  logic                           cnt_we,
  input  logic [CNT_WIDTH-1:0]           cnt_wdata,
  input  logic [$clog2(CNT_NUM)-1:0]     rd_idx,
  output logic [CNT_WIDTH-1:0]           rd_data,
  output logic [CNT_NUM-1:0]             ovf,
  input  logic                           dump_req,
  output logic                           dump_busy,
  output logic                           dump_valid,
  input  logic                           dump_ready,
  output logic [$clog2(CNT_NUM)-1:0]     dump_idx,
  output logic [CNT_WIDTH-1:0]           dump_data,
  output logic                           dump_done
);

  localparam int IDX_W = $clog2(CNT_NUM);
  localparam int SEL_W = $clog2(EVENT_NUM);

  logic [CNT_WIDTH-1:0] w_cnt     [CNT_NUM];
  logic [CNT_WIDTH-1:0] w_cnt_nxt [CNT_NUM];
  logic [CNT_WIDTH-1:0] r_shadow  [CNT_NUM];

  dump_state_t      r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_done, w_done_nxt;

  for (genvar g = 0; g < CNT_NUM; g++) begin : g_slot
    perf_counter_slot #(
      .EVENT_NUM(EVENT_NUM),
      .CNT_WIDTH(CNT_WIDTH),
      .INC_WIDTH(INC_WIDTH),
      .SEL_W    (SEL_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .event_inc(event_inc),
      .inhibit  (inhibit[g]),
      .sel_we   (cfg_we && (cfg_idx == IDX_W'(g))),
      .sel_wdata(cfg_sel),
      .cnt_we   (cnt_we && (cfg_idx == IDX_W'(g))),
      .cnt_wdata(cnt_wdata),
      .cnt      (w_cnt[g]),
      .cnt_nxt  (w_cnt_nxt[g]),
      .ovf      (ovf[g])
    );
  end

  // Registered read port returns the counter value before this cycle's update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= w_cnt[rd_idx];
  end

  // Dump sequencer next-state: snapshot once, then walk the shadow copies.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: if (dump_req) begin
        w_state_nxt = SNAP;
        w_idx_nxt   = '0;
      end
      SNAP: begin
        w_state_nxt = SEND;
        w_idx_nxt   = '0;
      end
      SEND: if (dump_ready) begin
        if (r_idx == IDX_W'(CNT_NUM-1)) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Dump sequencer state, beat index and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Shadow capture takes the post-update values so the snapshot includes this cycle's add/write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CNT_NUM; c++) r_shadow[c] <= '0;
    end else if (r_state == SNAP) begin
      for (int c = 0; c < CNT_NUM; c++) r_shadow[c] <= w_cnt_nxt[c];
    end
  end

  assign dump_busy  = (r_state != IDLE);
  assign dump_valid = (r_state == SEND);
  assign dump_idx   = r_idx;
  assign dump_data  = r_shadow[r_idx];
  assign dump_done  = r_done;

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Self-checking bench for perf_event_counter_bank with a cycle model scoreboard.
module tb_perf_event_counter_bank;
  import perf_event_counter_bank_pkg::*;

  localparam int EN = 32;
  localparam int CN = 8;
  localparam int IW = 3;

  logic            clk, rst;
  logic [EN*IW-1:0] event_inc;
  logic [CN-1:0]   inhibit;
  logic            cfg_we, cnt_we, dump_req, dump_ready;
  logic [2:0]      cfg_idx, rd_idx;
  logic [4:0]      cfg_sel;
  logic [63:0]     cnt_wdata;
  logic [63:0]     rd_data, dump_data;
  logic [CN-1:0]   ovf;
  logic            dump_busy, dump_valid, dump_done;
  logic [2:0]      dump_idx;

  int checks = 0;
  int errors = 0;

  perf_event_counter_bank dut (
    .clk(clk), .rst(rst), .event_inc(event_inc), .inhibit(inhibit),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel),
    .cnt_we(cnt_we), .cnt_wdata(cnt_wdata), .rd_idx(rd_idx), .rd_data(rd_data),
    .ovf(ovf), .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- reference model + read/ovf scoreboard ----------------
  logic [4:0]  m_sel  [CN];
  logic [2:0]  m_incq [CN];
  logic [63:0] m_cnt  [CN];
  logic [CN-1:0] m_ovf;
  logic [64:0] m_s;
  logic [63:0] m_rdx;
  logic [63:0]   rd_q  [$];
  logic [CN-1:0] ovf_q [$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CN; c++) begin
        m_sel[c] = '0; m_incq[c] = '0; m_cnt[c] = '0;
      end
      m_ovf = '0;
      rd_q.delete();
      ovf_q.delete();
    end else begin
      m_rdx = m_cnt[rd_idx];
      for (int c = 0; c < CN; c++) begin
        m_s = {1'b0, m_cnt[c]} + m_incq[c];
        if (cnt_we && cfg_idx == 3'(c)) begin
          m_cnt[c] = cnt_wdata;
          m_ovf[c] = 1'b0;
        end else begin
          m_cnt[c] = m_s[63:0];
          if (m_s[64]) m_ovf[c] = 1'b1;
        end
      end
      for (int c = 0; c < CN; c++)
        m_incq[c] = inhibit[c] ? 3'd0 : event_inc[m_sel[c]*IW +: IW];
      if (cfg_we) m_sel[cfg_idx] = cfg_sel;
      rd_q.push_back(m_rdx);
      ovf_q.push_back(m_ovf);
    end
  end

  always @(negedge clk) begin
    if (rst && rd_q.size() > 0) begin
      chk("sb_rd_data", rd_data, rd_q.pop_front());
      chk("sb_ovf", 64'(ovf), 64'(ovf_q.pop_front()));
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    int          cnt;
    int          evt;
    int          inc;
    int          cycles;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [4];
  perf_dump_beat_t bq [$];
  perf_dump_beat_t b;
  int done_cnt;
  bit held, found;
  logic [2:0]  h_idx;
  logic [63:0] h_data;

  task automatic setup_cnt(input int c, input int evt, input logic [63:0] val);
    event_inc = '0;
    cfg_we = 1'b1; cnt_we = 1'b1; cfg_idx = 3'(c); cfg_sel = 5'(evt); cnt_wdata = val;
    step();
    cfg_we = 1'b0; cnt_we = 1'b0;
    step(); step();
  endtask

  task automatic set_evt(input int evt, input int inc);
    event_inc[evt*IW +: IW] = 3'(inc);
  endtask

  initial begin
    rst = 1'b0; event_inc = '0; inhibit = '0; cfg_we = 0; cnt_we = 0; cfg_idx = 0;
    cfg_sel = 0; cnt_wdata = 0; rd_idx = 0; dump_req = 0; dump_ready = 0;

    vecs[0] = '{cnt: 0, evt: 3,  inc: 5, cycles: 4,  exp: 64'd20};
    vecs[1] = '{cnt: 5, evt: 31, inc: 7, cycles: 3,  exp: 64'd21};
    vecs[2] = '{cnt: 7, evt: 0,  inc: 1, cycles: 10, exp: 64'd10};
    vecs[3] = '{cnt: 3, evt: 17, inc: 2, cycles: 1,  exp: 64'd2};

    // reset state
    #22;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ovf", 64'(ovf), 0);
    chk("rst_busy", 64'(dump_busy), 0);
    chk("rst_valid", 64'(dump_valid), 0);
    chk("rst_done", 64'(dump_done), 0);
    chk("rst_dump_idx", 64'(dump_idx), 0);
    chk("rst_dump_data", dump_data, 0);
    step();
    rst = 1'b1;
    step();

    // table: accumulate and check read latency
    foreach (vecs[i]) begin
      setup_cnt(vecs[i].cnt, vecs[i].evt, 64'd0);
      rd_idx = 3'(vecs[i].cnt);
      for (int k = 0; k < vecs[i].cycles; k++) begin
        set_evt(vecs[i].evt, vecs[i].inc);
        step();
        chk("vec_latency", rd_data, 64'(vecs[i].inc * (k >= 1 ? k - 1 : 0)));
      end
      event_inc = '0;
      step(); step(); step();
      chk("vec_count", rd_data, vecs[i].exp);
      chk("vec_ovf", 64'(ovf[vecs[i].cnt]), 0);
    end

    // wrap and overflow, then write clears ovf and drops same-cycle add
    setup_cnt(1, 5, 64'hFFFF_FFFF_FFFF_FFFE);
    rd_idx = 3'd1;
    set_evt(5, 3); step();
    event_inc = '0; step(); step(); step();
    chk("wrap_cnt", rd_data, 64'd1);
    chk("wrap_ovf", 64'(ovf[1]), 1);
    set_evt(5, 3); step(); step();
    event_inc = '0; cnt_we = 1'b1; cfg_idx = 3'd1; cnt_wdata = 64'd0;
    step();
    cnt_we = 1'b0;
    step(); step(); step();
    chk("clr_cnt", rd_data, 64'd0);
    chk("clr_ovf", 64'(ovf[1]), 0);

    // inhibit freezes counter 2 for 3 cycles
    setup_cnt(2, 7, 64'd0);
    rd_idx = 3'd2;
    for (int k = 0; k < 7; k++) begin
      set_evt(7, 1);
      inhibit[2] = (k < 3);
      step();
      if (k == 4) chk("inh_frozen", rd_data, 64'd0);
      if (k == 5) chk("inh_resume", rd_data, 64'd1);
    end
    event_inc = '0; inhibit = '0;
    step(); step(); step();
    chk("inh_total", rd_data, 64'd4);

    // retarget counter 0 from event 3 to event 4 mid-stream
    setup_cnt(0, 3, 64'd0);
    rd_idx = 3'd0;
    for (int k = 0; k < 4; k++) begin
      set_evt(3, 1); set_evt(4, 2);
      cfg_we = (k == 1); cfg_idx = 3'd0; cfg_sel = 5'd4;
      step();
    end
    cfg_we = 1'b0; event_inc = '0;
    step(); step(); step();
    chk("retarget_cnt", rd_data, 64'd6);

    // preload 10*c and dump with toggling ready
    for (int c = 0; c < CN; c++) begin
      cnt_we = 1'b1; cfg_idx = 3'(c); cnt_wdata = 64'(10 * c);
      step();
      b.idx = 3'(c); b.data = 64'(10 * c);
      bq.push_back(b);
    end
    cnt_we = 1'b0;
    step(); step();
    dump_req = 1'b1; step(); dump_req = 1'b0;
    held = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      dump_ready = (cyc % 2 == 0);
      dump_req = (cyc == 4);
      @(negedge clk);
      if (dump_valid) begin
        if (held) begin
          chk("hold_idx", 64'(dump_idx), 64'(h_idx));
          chk("hold_data", dump_data, h_data);
        end
        if (dump_ready) begin
          if (bq.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_beat: got idx %0d expected none", dump_idx);
          end else begin
            b = bq.pop_front();
            chk("beat_idx", 64'(dump_idx), 64'(b.idx));
            chk("beat_data", dump_data, b.data);
          end
          held = 0;
        end else begin
          held = 1; h_idx = dump_idx; h_data = dump_data;
        end
      end
      if (dump_done) done_cnt++;
      step();
    end
    dump_req = 1'b0;
    chk("dump_done_count", 64'(done_cnt), 1);
    chk("dump_beats_left", 64'(bq.size()), 0);
    chk("dump_busy_after", 64'(dump_busy), 0);
    bq.delete();

    // reset in the middle of a dump
    dump_ready = 1'b1;
    dump_req = 1'b1; step(); dump_req = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (dump_valid && dump_idx == 3'd3) found = 1;
      else step();
    end
    chk("mid_reached_idx3", 64'(found), 1);
    dump_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(dump_valid), 0);
    chk("mid_rst_busy", 64'(dump_busy), 0);
    step(); step();
    rst = 1'b1;
    rd_idx = 3'd5;
    step();
    chk("post_rst_cnt5", rd_data, 64'd0);

    for (int c = 0; c < CN; c++) begin
      b.idx = 3'(c); b.data = 64'd0;
      bq.push_back(b);
    end
    dump_ready = 1'b1;
    dump_req = 1'b1; step(); dump_req = 1'b0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 30 && done_cnt == 0; cyc++) begin
      @(negedge clk);
      if (dump_valid && bq.size() > 0) begin
        b = bq.pop_front();
        chk("redump_idx", 64'(dump_idx), 64'(b.idx));
        chk("redump_data", dump_data, b.data);
      end
      if (dump_done) done_cnt++;
      step();
    end
    chk("redump_done", 64'(done_cnt), 1);
    chk("redump_beats_left", 64'(bq.size()), 0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_event_counter_bank.md
Name: perf_event_counter_bank

Overview:
Hardware performance-monitor bank that consumes the per-cycle event increments raised by pipeline stages: the same conditions that feed the simulation-only perf logging hooks. It provides CNT_NUM programmable counters, each selecting one of EVENT_NUM events, with a CSR-style read/write path and sticky overflow flags. A dump sequencer snapshots every counter and streams the values over a valid/ready port to the log/difftest sink.

Parameters:
EVENT_NUM, 32, number of event sources
CNT_NUM, 8, number of programmable counters
CNT_WIDTH, 64, counter width in bits
INC_WIDTH, 3, per-event per-cycle increment width (unsigned)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
event_inc  in  EVENT_NUM*INC_WIDTH  packed increments; event e occupies bits [e*INC_WIDTH +: INC_WIDTH]
inhibit  in  CNT_NUM  per-counter count freeze
cfg_we  in  1  event-select write strobe
cfg_idx  in  $clog2(CNT_NUM)  counter index for cfg_we/cnt_we
cfg_sel  in  $clog2(EVENT_NUM)  event select value
cnt_we  in  1  counter value write strobe
cnt_wdata  in  CNT_WIDTH  counter write value
rd_idx  in  $clog2(CNT_NUM)  read index
rd_data  out  CNT_WIDTH  registered read data
ovf  out  CNT_NUM  sticky overflow flags
dump_req  in  1  start dump (pulse)
dump_busy  out  1  dump in progress
dump_valid  out  1  dump beat valid
dump_ready  in  1  sink accepts beat
dump_idx  out  $clog2(CNT_NUM)  counter index of beat
dump_data  out  CNT_WIDTH  snapshot value of beat
dump_done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (rst low, async): all counters 0, all selects 0, ovf 0, rd_data 0, FSM IDLE, dump_busy/dump_valid/dump_done 0, dump_idx 0, dump_data 0, inc pipeline registers 0.
- Stage 0: per counter c, inc_q[c] <= inhibit[c] ? 0 : event_inc[sel[c]]. This uses the select register value current in that cycle.
- Stage 1: cnt[c] <= cnt[c] + zero-extended inc_q[c]. Event-to-count latency is 2 cycles.
- Overflow: a carry out of CNT_WIDTH wraps the counter mod 2^CNT_WIDTH and sets ovf[c].
- cfg_we: sel[cfg_idx] <= cfg_sel. Events sampled from the next cycle onward use the new select. The increment already in inc_q is still added.
- cnt_we: cnt[cfg_idx] <= cnt_wdata and ovf[cfg_idx] <= 0. It has priority over the same-cycle stage-1 add to that counter, so the increment is dropped. Other counters are unaffected.
- cfg_we and cnt_we in the same cycle are both applied.
- Read: rd_data <= cnt[rd_idx], the pre-update register value. Latency is 1 cycle. Reads are always enabled.
- Dump FSM:
  - IDLE: on dump_req, go to SNAP and set dump_busy = 1.
  - SNAP: shadow[c] <= cnt[c] for all c, using the value as of the end of this cycle (includes this cycle's add or write). Next state SEND with dump_idx = 0.
  - SEND: dump_valid = 1, dump_data = shadow[dump_idx]. On valid && ready: if dump_idx == CNT_NUM-1, go to IDLE, pulse dump_done, clear dump_busy; else dump_idx + 1. dump_valid/dump_idx/dump_data are held stable while ready is low.
  - dump_req outside IDLE is ignored.
  - Counters keep counting and remain writable during a dump; snapshot values are unaffected.
  - A dump of CNT_NUM beats with ready held high takes 1 + CNT_NUM cycles from SNAP to done.
- Reset mid-dump: the FSM returns to IDLE immediately and the partial dump is discarded.
- Out-of-range cfg_sel (when EVENT_NUM is not a power of 2) selects increment 0.

Decomposition:
- Shared perf package holds:
  - dump_state_t enum (IDLE, SNAP, SEND);
  - localparams CNT_IDX_W = $clog2(CNT_NUM) and EVT_IDX_W = $clog2(EVENT_NUM);
  - typedef perf_dump_beat_t {idx, data}.
- One sub-module, perf_counter_slot: select mux, inc pipeline register, counter, overflow flag and write priority. It is instantiated CNT_NUM times.
- Dump FSM and read mux stay in the top module.

Test Plan:
1. Select event 3 on counter 0; drive inc=5 on event 3 for 4 cycles, then 0 -> cnt0 reads 20, first increment is visible 2 cycles after drive, ovf[0] = 0.
2. cnt_we counter 1 = 2^64-2, event inc=3 every cycle -> next value wraps to 1 and ovf[1] = 1. A later cnt_we to counter 1 with value 0 clears ovf[1]; the same-cycle increment is dropped and cnt1 = 0.
3. inhibit[2] held high for 3 cycles with continuous inc=1 -> cnt2 does not advance during those cycles, counting resumes 2 cycles after release.
4. cfg_we retargets counter 0 from event 3 to event 4 while both are active (inc 1 and 2) -> exactly one cycle's event-3 increment is still added after the write, then the counter advances by +2 per cycle.
5. Preload counters to 10·c, pulse dump_req, ready toggles 1,0,1,... -> 8 beats idx 0..7 with data 0,10,...,70 held stable while ready is low, dump_done pulses once. A second dump_req during SEND is ignored.
6. Assert rst during SEND beat idx 3 -> dump_valid/dump_busy drop asynchronously, counters read 0 after release. A new dump_req then streams from idx 0.
